// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - LED bank sequencer: bounce, rotate left/right, fill/drain bar
// Optional LED_PWM_EN adds a duty input and registered PWM gating of the LED outputs.
module led_pattern_engine #(
  parameter int BITS  = 10,
  parameter int SEG   = 1,
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [DIV_W-1:0] div,
`ifdef LED_PWM_EN
  input  logic [3:0]       duty,
`endif
  output logic [BITS-1:0]  qLeds,
  output logic             step,
  output logic             wrap
);

  localparam logic [BITS-1:0] INIT_SCAN = {{(BITS-SEG){1'b0}}, {SEG{1'b1}}};
  localparam logic [BITS-1:0] INIT_BAR  = {{(BITS-1){1'b0}}, 1'b1};

  localparam logic [1:0] MODE_BOUNCE = 2'b00;
  localparam logic [1:0] MODE_ROL    = 2'b01;
  localparam logic [1:0] MODE_ROR    = 2'b10;
  localparam logic [1:0] MODE_BAR    = 2'b11;

  typedef enum logic {DIR_LEFT = 1'b0, DIR_RIGHT = 1'b1} dir_e;

  logic [1:0]       mode_q, mode_d;
  dir_e             dir_q, dir_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [BITS-1:0]  pat_q, pat_d;
  logic             step_q, step_d;
  logic             wrap_q, wrap_d;

  logic             mode_chg;
  logic             tick;
  logic [BITS-1:0]  init_cur;
  logic [BITS-1:0]  init_new;
  logic [BITS-1:0]  step_pat;
  dir_e             step_dir;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q <= MODE_BOUNCE;
      dir_q  <= DIR_LEFT;
      cnt_q  <= '0;
      pat_q  <= INIT_SCAN;
      step_q <= 1'b0;
      wrap_q <= 1'b0;
    end else begin
      mode_q <= mode_d;
      dir_q  <= dir_d;
      cnt_q  <= cnt_d;
      pat_q  <= pat_d;
      step_q <= step_d;
      wrap_q <= wrap_d;
    end
  end

  // Pattern advance for the current mode/direction, used only on a tick.
  always_comb begin
    step_pat = pat_q;
    step_dir = dir_q;
    case (mode_q)
      MODE_BOUNCE: begin
        if (dir_q == DIR_LEFT) begin
          step_pat = pat_q << 1;
          if (pat_q[BITS-2]) step_dir = DIR_RIGHT;
        end else begin
          step_pat = pat_q >> 1;
          if (pat_q[1]) step_dir = DIR_LEFT;
        end
      end
      MODE_ROL: step_pat = {pat_q[BITS-2:0], pat_q[BITS-1]};
      MODE_ROR: step_pat = {pat_q[0], pat_q[BITS-1:1]};
      default: begin
        if (dir_q == DIR_LEFT) begin
          step_pat = (pat_q << 1) | INIT_BAR;
          if (&step_pat) step_dir = DIR_RIGHT;
        end else begin
          step_pat = pat_q >> 1;
          if (step_pat == INIT_BAR) step_dir = DIR_LEFT;
        end
      end
    endcase
  end

  // Mode reload wins over a coincident tick and happens even while disabled.
  always_comb begin
    mode_d = mode_q;
    dir_d  = dir_q;
    cnt_d  = cnt_q;
    pat_d  = pat_q;
    step_d = 1'b0;
    wrap_d = 1'b0;
    if (mode_chg) begin
      mode_d = mode;
      dir_d  = DIR_LEFT;
      cnt_d  = '0;
      pat_d  = init_new;
    end else if (tick) begin
      cnt_d  = '0;
      pat_d  = step_pat;
      dir_d  = step_dir;
      step_d = 1'b1;
      wrap_d = (step_pat == init_cur);
    end else if (en) begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  always_comb begin
    mode_chg = (mode != mode_q);
    tick     = en && (cnt_q >= div);
    init_cur = (mode_q == MODE_BAR) ? INIT_BAR : INIT_SCAN;
    init_new = (mode == MODE_BAR) ? INIT_BAR : INIT_SCAN;
  end

  assign step = step_q;
  assign wrap = wrap_q;

`ifdef LED_PWM_EN
  logic [3:0]      pwm_q;
  logic [BITS-1:0] leds_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pwm_q  <= 4'd0;
      leds_q <= INIT_SCAN;
    end else begin
      pwm_q  <= pwm_q + 4'd1;
      leds_q <= pat_d & {BITS{pwm_q < duty}};
    end
  end

  assign qLeds = leds_q;
`else
  assign qLeds = pat_q;
`endif

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - table-driven scoreboard bench for led_pattern_engine (BITS=4, SEG=1)
// Build with LED_PWM_EN defined to exercise the PWM gating instead of the pattern table.
module tb_led_pattern_engine;

  localparam int BITS  = 4;
  localparam int SEG   = 1;
  localparam int DIV_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic [1:0]       mode;
  logic [DIV_W-1:0] div;
  logic [3:0]       duty;
  logic [BITS-1:0]  qLeds;
  logic             step;
  logic             wrap;

  always #5 clk = ~clk;

  led_pattern_engine #(.BITS(BITS), .SEG(SEG), .DIV_W(DIV_W)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .mode  (mode),
    .div   (div),
`ifdef LED_PWM_EN
    .duty  (duty),
`endif
    .qLeds (qLeds),
    .step  (step),
    .wrap  (wrap)
  );

  typedef struct {
    logic [1:0]       mode;
    logic             en;
    logic [DIV_W-1:0] div;
    logic [BITS-1:0]  leds;
    logic             step;
    logic             wrap;
  } vec_t;

  typedef struct {
    logic [BITS-1:0] leds;
    logic            step;
    logic            wrap;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic add(input logic [1:0] m, input logic e, input int d,
                     input logic [BITS-1:0] l, input logic s, input logic w, input int rep = 1);
    vec_t v;
    v.mode = m; v.en = e; v.div = DIV_W'(d); v.leds = l; v.step = s; v.wrap = w;
    for (int i = 0; i < rep; i++) vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [BITS-1:0] l, input logic s, input logic w);
    n_vec++;
    if (qLeds !== l || step !== s || wrap !== w) begin
      n_fail++;
      $display("FAIL %s: got qLeds=%b step=%b wrap=%b, want qLeds=%b step=%b wrap=%b",
               name, qLeds, step, wrap, l, s, w);
    end
  endtask

  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    mode = v.mode; en = v.en; div = v.div;
    e.leds = v.leds; e.step = v.step; e.wrap = v.wrap;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check($sformatf("vec%0d", idx), e.leds, e.step, e.wrap);
  endtask

`ifdef LED_PWM_EN
  task automatic pwm_window(input logic [3:0] d, input int want);
    int lit = 0;
    int dark_hi = 0;
    duty = d;
    repeat (20) @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      if (qLeds[0]) lit++;
      if (qLeds[BITS-1:1] != '0) dark_hi++;
    end
    n_vec++;
    if (lit != want || dark_hi != 0) begin
      n_fail++;
      $display("FAIL pwm_duty%0d: got %0d lit cycles (%0d upper-bit leaks), want %0d",
               d, lit, dark_hi, want);
    end
  endtask
`endif

  initial begin
    rst = 1'b1; en = 1'b1; mode = 2'b00; div = '0; duty = 4'd0;
    #2;
    check("reset", 4'b0001, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;

`ifdef LED_PWM_EN
    en = 1'b0;
    pwm_window(4'd4, 4);
    pwm_window(4'd0, 0);
    pwm_window(4'd15, 15);
`else
    // bounce, div=0
    add(2'b00, 1, 0, 4'b0010, 1, 0);
    add(2'b00, 1, 0, 4'b0100, 1, 0);
    add(2'b00, 1, 0, 4'b1000, 1, 0);
    add(2'b00, 1, 0, 4'b0100, 1, 0);
    add(2'b00, 1, 0, 4'b0010, 1, 0);
    add(2'b00, 1, 0, 4'b0001, 1, 1);
    add(2'b00, 1, 0, 4'b0010, 1, 0);
    add(2'b00, 1, 0, 4'b0100, 1, 0);
    // switch to rotate right on a tick cycle
    add(2'b10, 1, 0, 4'b0001, 0, 0);
    add(2'b10, 1, 0, 4'b1000, 1, 0);
    add(2'b10, 1, 0, 4'b0100, 1, 0);
    add(2'b10, 1, 0, 4'b0010, 1, 0);
    add(2'b10, 1, 0, 4'b0001, 1, 1);
    // bar
    add(2'b11, 1, 0, 4'b0001, 0, 0);
    add(2'b11, 1, 0, 4'b0011, 1, 0);
    add(2'b11, 1, 0, 4'b0111, 1, 0);
    add(2'b11, 1, 0, 4'b1111, 1, 0);
    add(2'b11, 1, 0, 4'b0111, 1, 0);
    add(2'b11, 1, 0, 4'b0011, 1, 0);
    add(2'b11, 1, 0, 4'b0001, 1, 1);
    add(2'b11, 1, 0, 4'b0011, 1, 0);
    // rotate left, div=3
    add(2'b01, 1, 3, 4'b0001, 0, 0);
    add(2'b01, 1, 3, 4'b0001, 0, 0, 3);
    add(2'b01, 1, 3, 4'b0010, 1, 0);
    add(2'b01, 1, 3, 4'b0010, 0, 0, 3);
    add(2'b01, 1, 3, 4'b0100, 1, 0);
    add(2'b01, 1, 3, 4'b0100, 0, 0, 3);
    add(2'b01, 1, 3, 4'b1000, 1, 0);
    add(2'b01, 1, 3, 4'b1000, 0, 0, 3);
    add(2'b01, 1, 3, 4'b0001, 1, 1);
    // lowering div below the running count ticks at once
    add(2'b01, 1, 3, 4'b0001, 0, 0, 2);
    add(2'b01, 1, 1, 4'b0010, 1, 0);
    // freeze with en low: count held at 1
    add(2'b01, 1, 3, 4'b0010, 0, 0);
    add(2'b01, 0, 3, 4'b0010, 0, 0, 10);
    add(2'b01, 1, 3, 4'b0010, 0, 0, 2);
    add(2'b01, 1, 3, 4'b0100, 1, 0);
    // reload while disabled
    add(2'b00, 0, 0, 4'b0001, 0, 0);
    add(2'b00, 0, 0, 4'b0001, 0, 0);
    add(2'b00, 1, 0, 4'b0010, 1, 0);

    for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

    // asynchronous reset between edges
    #3 rst = 1'b1;
    #1 check("async_rst", 4'b0001, 1'b0, 1'b0);
    @(posedge clk);
    #1 rst = 1'b0;
    vecs.delete();
    add(2'b00, 1, 0, 4'b0010, 1, 0);
    apply(vecs[0], 999);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
